periph_bus_arbiter: RTL

- Round-robin arbiter that shares one memory-mapped peripheral slave port (valid/ready/wstrb/addr/wdata/rdata) among N masters, for example a CPU and a DMA engine driving the GPIO/register peripherals.
- Holds the grant for exactly one transaction.
- Inserts one idle cycle between transactions so registered-ready slaves see valid low.
- Exposes the current grant for debug.

---
 rtl/periph_bus_pkg.sv | 20 ++
 rtl/periph_bus_arbiter_rr_pick.sv | 33 +++
 rtl/periph_bus_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/periph_bus_pkg.sv
// Shared constants and types for the peripheral bus arbiter family.
package periph_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [DATA_W-1:0] BUS_ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/periph_bus_arbiter_rr_pick.sv
// Combinational cyclic first-one finder: the first set request at or after ptr,
// returned both one-hot and as an index.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  // Walk from the farthest offset back to ptr so the nearest requester is written last.
  always_comb begin
    int          j;
    logic [IW-1:0] jidx;
    onehot = '0;
    idx    = '0;
    j      = 0;
    jidx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jidx = IW'(j);
      if (req[jidx]) begin
        onehot       = '0;
        onehot[jidx] = 1'b1;
        idx          = jidx;
      end
    end
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter sharing one valid/ready peripheral slave port among N masters,
// one transaction per grant. Optional slave timeout under PERIPH_ARB_TIMEOUT_EN.
module periph_bus_arbiter
  import periph_bus_pkg::*;
#(
  parameter int N_MASTERS      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [N_MASTERS-1:0]          m_valid,
  output logic [N_MASTERS-1:0]          m_ready,
  input  logic [STRB_W*N_MASTERS-1:0]   m_wstrb,
  input  logic [ADDR_W*N_MASTERS-1:0]   m_addr,
  input  logic [DATA_W*N_MASTERS-1:0]   m_wdata,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_valid,
  input  logic                          s_ready,
  output logic [STRB_W-1:0]             s_wstrb,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic [DATA_W-1:0]             s_rdata,
  output logic [N_MASTERS-1:0]          grant,
  output logic                          bus_err
);

  localparam int IW = idx_width(N_MASTERS);

  if (N_MASTERS < 2 || N_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("periph_bus_arbiter: unsupported N_MASTERS or TIMEOUT_CYCLES");
  end

  arb_state_e           state, state_nxt;
  logic [N_MASTERS-1:0] grant_q, pick_oh;
  logic [IW-1:0]        gidx, ptr, ptr_nxt, pick_idx;
  logic                 busy, owner_valid, done, abandon, timeout;

  rr_pick #(.N(N_MASTERS), .IW(IW)) u_pick (
    .req    (m_valid),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  assign busy        = (state == ARB_BUSY);
  assign owner_valid = busy & m_valid[gidx];
  assign done        = owner_valid & s_ready;
  assign abandon     = busy & ~m_valid[gidx];
  assign ptr_nxt     = (gidx == IW'(N_MASTERS - 1)) ? '0 : gidx + IW'(1);
  assign grant       = grant_q;

`ifdef PERIPH_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmo_cnt;
  logic          err_q;

  // tmo_cnt holds the ready-less BUSY cycles already elapsed, so the limit fires in cycle TIMEOUT_CYCLES.
  assign timeout = owner_valid & ~s_ready & (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign bus_err = err_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (!busy)         tmo_cnt <= '0;
      else if (!s_ready) tmo_cnt <= tmo_cnt + CW'(1);
      if (timeout)       err_q   <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) state <= ARB_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (|m_valid) state_nxt = ARB_BUSY;
      ARB_BUSY: if (done | abandon | timeout) state_nxt = ARB_IDLE;
    endcase
  end

  // Grant and pointer only move on the IDLE->BUSY and BUSY->IDLE transitions.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      grant_q <= '0;
      gidx    <= '0;
      ptr     <= '0;
    end else if (!busy && (|m_valid)) begin
      grant_q <= pick_oh;
      gidx    <= pick_idx;
    end else if (busy && state_nxt == ARB_IDLE) begin
      grant_q <= '0;
      ptr     <= ptr_nxt;
    end
  end

  always_comb begin
    s_valid = owner_valid;
    s_wstrb = '0;
    s_addr  = '0;
    s_wdata = '0;
    m_ready = '0;
    m_rdata = s_rdata;
    if (busy) begin
      s_wstrb = m_wstrb[gidx*STRB_W +: STRB_W];
      s_addr  = m_addr[gidx*ADDR_W +: ADDR_W];
      s_wdata = m_wdata[gidx*DATA_W +: DATA_W];
    end
    if (done | timeout) m_ready[gidx] = 1'b1;
    if (timeout)        m_rdata       = BUS_ERR_RDATA;
  end

endmodule
